// File: rtl/control_sequencer.sv
// Hardwired Mini SRC control unit: fetch/decode/execute sequencer that drives
// every datapath control input from its state and the IR contents.
module control_sequencer #(
   parameter logic [4:0] BDS_HI  = 5'd16,
   parameter logic [4:0] BDS_LO  = 5'd17,
   parameter logic [4:0] BDS_ZHI = 5'd18,
   parameter logic [4:0] BDS_ZLO = 5'd19,
   parameter logic [4:0] BDS_PC  = 5'd20,
   parameter logic [4:0] BDS_MDR = 5'd21
) (
   input  logic        clock,
   input  logic        clear,
   input  logic [31:0] IR_in,
   input  logic        mem_rdy,
   output logic [4:0]  BusDataSelect,
   output logic [3:0]  GP_addr,
   output logic        e_PC,
   output logic        e_IR,
   output logic        e_Y,
   output logic        e_Z,
   output logic        e_HI,
   output logic        e_LO,
   output logic        e_MDR,
   output logic        e_MAR,
   output logic        e_GP,
   output logic        incPC,
   output logic        MDR_read,
   output logic [3:0]  ALU_op,
   output logic        mem_read,
   output logic        run,
   output logic        illegal,
   output logic [3:0]  state_out
);

   typedef enum logic [3:0] {
      S_RST  = 4'd0,
      S_T0   = 4'd1,
      S_T1   = 4'd2,
      S_T2   = 4'd3,
      S_T3   = 4'd4,
      S_T4   = 4'd5,
      S_T5   = 4'd6,
      S_T6   = 4'd7,
      S_HALT = 4'd8
   } state_t;

   state_t     state_q, state_d;
   logic       illegal_q, illegal_d;

   logic [4:0] opcode;
   logic [3:0] ra, rb, rc;
   logic       is_alu, is_md, is_nop, is_halt;
   logic [3:0] alu_dec;

   // HI/LO bus codes belong to the datapath map but no state here sources them.
   logic [24:0] unused_bits;
   assign unused_bits = {IR_in[14:0], BDS_HI, BDS_LO};

   assign opcode = IR_in[31:27];
   assign ra     = IR_in[26:23];
   assign rb     = IR_in[22:19];
   assign rc     = IR_in[18:15];

   always_comb begin
      is_alu  = 1'b0;
      is_md   = 1'b0;
      is_nop  = 1'b0;
      is_halt = 1'b0;
      alu_dec = 4'b0000;
      case (opcode)
         5'b00000: begin is_alu = 1'b1; alu_dec = 4'b0000; end
         5'b00001: begin is_alu = 1'b1; alu_dec = 4'b0001; end
         5'b00010: begin is_alu = 1'b1; alu_dec = 4'b0010; end
         5'b00011: begin is_alu = 1'b1; alu_dec = 4'b0011; end
         5'b00100: begin is_alu = 1'b1; alu_dec = 4'b0110; end
         5'b00101: begin is_alu = 1'b1; alu_dec = 4'b1001; end
         5'b00110: begin is_alu = 1'b1; alu_dec = 4'b1010; end
         5'b00111: begin is_alu = 1'b1; alu_dec = 4'b0111; end
         5'b01000: begin is_md  = 1'b1; alu_dec = 4'b0100; end
         5'b01001: begin is_md  = 1'b1; alu_dec = 4'b0101; end
         5'b11010: is_nop  = 1'b1;
         5'b11011: is_halt = 1'b1;
         default:  ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state_q   <= S_RST;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      illegal_d     = illegal_q;
      BusDataSelect = 5'd0;
      GP_addr       = 4'd0;
      e_PC          = 1'b0;
      e_IR          = 1'b0;
      e_Y           = 1'b0;
      e_Z           = 1'b0;
      e_HI          = 1'b0;
      e_LO          = 1'b0;
      e_MDR         = 1'b0;
      e_MAR         = 1'b0;
      e_GP          = 1'b0;
      incPC         = 1'b0;
      MDR_read      = 1'b0;
      ALU_op        = 4'b0000;
      mem_read      = 1'b0;
      run           = 1'b1;
      case (state_q)
         S_RST: begin
            run     = 1'b0;
            state_d = S_T0;
         end
         S_T0: begin
            BusDataSelect = BDS_PC;
            e_MAR         = 1'b1;
            incPC         = 1'b1;
            e_Z           = 1'b1;
            state_d       = S_T1;
         end
         // PC reload every wait cycle is harmless: Z still holds PC+1.
         S_T1: begin
            BusDataSelect = BDS_ZLO;
            e_PC          = 1'b1;
            mem_read      = 1'b1;
            MDR_read      = 1'b1;
            e_MDR         = 1'b1;
            if (mem_rdy) state_d = S_T2;
         end
         S_T2: begin
            BusDataSelect = BDS_MDR;
            e_IR          = 1'b1;
            state_d       = S_T3;
         end
         S_T3: begin
            if (is_alu || is_md) begin
               BusDataSelect = is_md ? {1'b0, ra} : {1'b0, rb};
               e_Y           = 1'b1;
               state_d       = S_T4;
            end else if (is_nop) begin
               state_d = S_T0;
            end else if (is_halt) begin
               state_d = S_HALT;
            end else begin
               illegal_d = 1'b1;
               state_d   = S_T0;
            end
         end
         S_T4: begin
            BusDataSelect = is_md ? {1'b0, rb} : {1'b0, rc};
            ALU_op        = alu_dec;
            e_Z           = 1'b1;
            state_d       = S_T5;
         end
         S_T5: begin
            BusDataSelect = BDS_ZLO;
            if (is_md) begin
               e_LO    = 1'b1;
               state_d = S_T6;
            end else begin
               GP_addr = ra;
               e_GP    = 1'b1;
               state_d = S_T0;
            end
         end
         S_T6: begin
            BusDataSelect = BDS_ZHI;
            e_HI          = 1'b1;
            state_d       = S_T0;
         end
         S_HALT: begin
            run = 1'b0;
         end
         default: begin
            run     = 1'b0;
            state_d = S_RST;
         end
      endcase
   end

   assign illegal   = illegal_q;
   assign state_out = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: every cycle's full control vector is
// compared against a hand-written expectation.
module tb_control_sequencer;

   logic        clock;
   logic        clear;
   logic [31:0] IR_in;
   logic        mem_rdy;
   logic [4:0]  BusDataSelect;
   logic [3:0]  GP_addr;
   logic        e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP;
   logic        incPC, MDR_read, mem_read, run, illegal;
   logic [3:0]  ALU_op;
   logic [3:0]  state_out;

   int checks   = 0;
   int failures = 0;

   localparam logic [8:0] EN_PC  = 9'h100;
   localparam logic [8:0] EN_IR  = 9'h080;
   localparam logic [8:0] EN_Y   = 9'h040;
   localparam logic [8:0] EN_Z   = 9'h020;
   localparam logic [8:0] EN_HI  = 9'h010;
   localparam logic [8:0] EN_LO  = 9'h008;
   localparam logic [8:0] EN_MDR = 9'h004;
   localparam logic [8:0] EN_MAR = 9'h002;
   localparam logic [8:0] EN_GP  = 9'h001;

   localparam logic [31:0] IR_ROL  = 32'h2A338000;
   localparam logic [31:0] IR_MUL  = 32'h41180000;
   localparam logic [31:0] IR_NOP  = 32'hD0000000;
   localparam logic [31:0] IR_ILL  = 32'hF8000000;
   localparam logic [31:0] IR_HALT = 32'hD8000000;

   control_sequencer dut (
      .clock         (clock),
      .clear         (clear),
      .IR_in         (IR_in),
      .mem_rdy       (mem_rdy),
      .BusDataSelect (BusDataSelect),
      .GP_addr       (GP_addr),
      .e_PC          (e_PC),
      .e_IR          (e_IR),
      .e_Y           (e_Y),
      .e_Z           (e_Z),
      .e_HI          (e_HI),
      .e_LO          (e_LO),
      .e_MDR         (e_MDR),
      .e_MAR         (e_MAR),
      .e_GP          (e_GP),
      .incPC         (incPC),
      .MDR_read      (MDR_read),
      .ALU_op        (ALU_op),
      .mem_read      (mem_read),
      .run           (run),
      .illegal       (illegal),
      .state_out     (state_out)
   );

   // Clock / watchdog
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [31:0] obs_vec;
   assign obs_vec = {1'b0, state_out, BusDataSelect, GP_addr,
                     e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP,
                     incPC, MDR_read, ALU_op, mem_read, run, illegal};

   function automatic logic [31:0] ev(input logic [3:0] st, input logic [4:0] bds,
                                      input logic [3:0] gp, input logic [8:0] en,
                                      input logic inc, input logic mdrr,
                                      input logic [3:0] alu, input logic memrd,
                                      input logic rn, input logic ill);
      return {1'b0, st, bds, gp, en, inc, mdrr, alu, memrd, rn, ill};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   // Advance one cycle and compare the control vector at the falling edge.
   task automatic expect_cycle(input string tag, input logic [31:0] want);
      @(negedge clock);
      check_eq(tag, obs_vec, want);
   endtask

   // T0..T2 of a fetch with mem_rdy high; IR is loaded on the T2 edge.
   task automatic fetch(input string tag, input logic [31:0] ir, input logic ill);
      expect_cycle({tag, "_t0"}, ev(4'd1, 5'd20, 4'd0, EN_MAR | EN_Z, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, ill));
      expect_cycle({tag, "_t1"}, ev(4'd2, 5'd19, 4'd0, EN_PC | EN_MDR, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, ill));
      expect_cycle({tag, "_t2"}, ev(4'd3, 5'd21, 4'd0, EN_IR, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, ill));
      IR_in = ir;
   endtask

   task automatic run_rol(input logic ill);
      fetch("rol", IR_ROL, ill);
      expect_cycle("rol_t3", ev(4'd4, 5'd6, 4'd0, EN_Y, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, ill));
      expect_cycle("rol_t4", ev(4'd5, 5'd7, 4'd0, EN_Z, 1'b0, 1'b0, 4'b1001, 1'b0, 1'b1, ill));
   endtask

   initial begin
      clear   = 1'b1;
      mem_rdy = 1'b1;
      IR_in   = 32'h0;

      @(negedge clock);
      expect_cycle("reset", ev(4'd0, 5'd0, 4'd0, 9'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
      clear = 1'b0;

      // rol R4,R6,R7
      run_rol(1'b0);
      expect_cycle("rol_t5", ev(4'd6, 5'd19, 4'd4, EN_GP, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0));

      // mul R2,R3 (starts in T0, cycle 7 of the rol sequence)
      fetch("mul", IR_MUL, 1'b0);
      expect_cycle("mul_t3", ev(4'd4, 5'd2, 4'd0, EN_Y, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0));
      expect_cycle("mul_t4", ev(4'd5, 5'd3, 4'd0, EN_Z, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b1, 1'b0));
      expect_cycle("mul_t5", ev(4'd6, 5'd19, 4'd0, EN_LO, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0));
      expect_cycle("mul_t6", ev(4'd7, 5'd18, 4'd0, EN_HI, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0));

      // Memory wait: mem_rdy low on three T1 edges gives four T1 cycles.
      expect_cycle("wait_t0", ev(4'd1, 5'd20, 4'd0, EN_MAR | EN_Z, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0));
      mem_rdy = 1'b0;
      for (int i = 0; i < 4; i++)
         expect_cycle($sformatf("wait_t1_%0d", i),
                      ev(4'd2, 5'd19, 4'd0, EN_PC | EN_MDR, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0));
      mem_rdy = 1'b1;
      expect_cycle("wait_t2", ev(4'd3, 5'd21, 4'd0, EN_IR, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0));
      IR_in = IR_NOP;
      expect_cycle("nop_t3", ev(4'd4, 5'd0, 4'd0, 9'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0));

      // Illegal opcode sets the sticky flag from the next cycle on.
      fetch("ill", IR_ILL, 1'b0);
      expect_cycle("ill_t3", ev(4'd4, 5'd0, 4'd0, 9'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0));
      fetch("ill_nop", IR_NOP, 1'b1);
      expect_cycle("ill_nop_t3", ev(4'd4, 5'd0, 4'd0, 9'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1));

      // Halt holds with run low until clear.
      fetch("halt", IR_HALT, 1'b1);
      expect_cycle("halt_t3", ev(4'd4, 5'd0, 4'd0, 9'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1));
      for (int i = 0; i < 20; i++)
         expect_cycle($sformatf("halt_%0d", i),
                      ev(4'd8, 5'd0, 4'd0, 9'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1));
      clear = 1'b1;
      expect_cycle("halt_clr", ev(4'd0, 5'd0, 4'd0, 9'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
      clear = 1'b0;

      // Set illegal again, then abort a rol in T4 with clear.
      fetch("ill2", IR_ILL, 1'b0);
      expect_cycle("ill2_t3", ev(4'd4, 5'd0, 4'd0, 9'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0));
      run_rol(1'b1);
      clear = 1'b1;
      expect_cycle("abort_rst", ev(4'd0, 5'd0, 4'd0, 9'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
      clear = 1'b0;
      expect_cycle("abort_t0", ev(4'd1, 5'd20, 4'd0, EN_MAR | EN_Z, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0));
      expect_cycle("abort_t1", ev(4'd2, 5'd19, 4'd0, EN_PC | EN_MDR, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
